// File: rtl/alu_datamem_32_if.sv
// Bus bundle for the execute/memory stage.
// The master side supplies the control, the operands and the store data.
// The slave side returns the decoded operation, the ALU results and the load data.
interface alu_datamem_32_if;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic [31:0] buffer;
  logic        zero;
  logic [31:0] read_data;

  modport master (
    output alu_op, funct, a, b, write_data, mem_write, mem_read,
    input  alu_control, alu_result, buffer, zero, read_data
  );

  modport slave (
    input  alu_op, funct, a, b, write_data, mem_write, mem_read,
    output alu_control, alu_result, buffer, zero, read_data
  );
endinterface

// File: rtl/alu_datamem_32.sv
// Execute/memory stage of the single-cycle MIPS datapath.
// The stage holds the ALU-control decode, a 32-bit ALU with a zero flag, and a MULT high-word buffer.
// It also holds a word-addressed data memory, which the ALU result addresses.
// Everything is combinational except the memory array.
// The memory array writes on the rising clock edge and is cleared by the asynchronous reset.
module alu_datamem_32 #(
  parameter int MEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_datamem_32_if.slave bus
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_MUL = 4'b0011;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_BAD = 4'b1111;

  logic [3:0]        alu_control_s;
  logic [31:0]       alu_result_s;
  logic [31:0]       buffer_s;
  logic [63:0]       product_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [31:0]       read_data_s;
  logic [31:0]       mem_r [MEM_WORDS];

  // Decode ALUOp and funct into the 4-bit ALU operation code.
  always_comb begin
    alu_control_s = CTL_BAD;
    case (bus.alu_op)
      2'b00: alu_control_s = CTL_ADD;
      2'b01: alu_control_s = CTL_SUB;
      2'b11: alu_control_s = CTL_OR;
      2'b10: begin
        case (bus.funct)
          6'b100000: alu_control_s = CTL_ADD;
          6'b100010: alu_control_s = CTL_SUB;
          6'b100100: alu_control_s = CTL_AND;
          6'b100101: alu_control_s = CTL_OR;
          6'b101010: alu_control_s = CTL_SLT;
          6'b100111: alu_control_s = CTL_NOR;
          6'b011000: alu_control_s = CTL_MUL;
          default:   alu_control_s = CTL_BAD;
        endcase
      end
      default: alu_control_s = CTL_BAD;
    endcase
  end

  // Both operands are sign-extended to 64 bits, so the low 64 bits of the product are the signed product.
  assign product_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};

  // Compute the ALU result and the MULT high word. Undefined codes produce zeros.
  always_comb begin
    alu_result_s = 32'd0;
    buffer_s     = 32'd0;
    case (alu_control_s)
      CTL_AND: alu_result_s = bus.a & bus.b;
      CTL_OR:  alu_result_s = bus.a | bus.b;
      CTL_ADD: alu_result_s = bus.a + bus.b;
      CTL_SUB: alu_result_s = bus.a - bus.b;
      CTL_SLT: alu_result_s = {31'd0, ($signed(bus.a) < $signed(bus.b))};
      CTL_NOR: alu_result_s = ~(bus.a | bus.b);
      CTL_MUL: begin
        alu_result_s = product_s[31:0];
        buffer_s     = product_s[63:32];
      end
      default: begin
        alu_result_s = 32'd0;
        buffer_s     = 32'd0;
      end
    endcase
  end

  // The byte offset and the address bits above the memory size are dropped, so addresses alias.
  assign word_idx_s = alu_result_s[ADDR_W+1:2];

  // Store the word on the clock edge. While reset is low, the whole array is held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (bus.mem_write) begin
      mem_r[word_idx_s] <= bus.write_data;
    end
  end

  // Load port: the read is combinational and returns zero when it is not enabled or when reset is low.
  always_comb begin
    read_data_s = 32'd0;
    if (rst_n && bus.mem_read) begin
      read_data_s = mem_r[word_idx_s];
    end else begin
      read_data_s = 32'd0;
    end
  end

  assign bus.alu_control = alu_control_s;
  assign bus.alu_result  = alu_result_s;
  assign bus.buffer      = buffer_s;
  assign bus.zero        = (alu_result_s == 32'd0);
  assign bus.read_data   = read_data_s;

endmodule

// File: tb/tb_alu_datamem_32.sv
// Self-checking bench for alu_datamem_32.
// The bench covers directed corner cases and randomized operations, checked against a behavioural model.
module tb_alu_datamem_32;

  localparam int MW = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] model_mem [MW];
  logic [5:0]  fn_tab [8];

  alu_datamem_32_if bus ();

  alu_datamem_32 #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when the observed value differs from the expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      6'b011000: return 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  task automatic ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [31:0] h);
    longint p;
    r = 32'd0;
    h = 32'd0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(x | y);
      4'b0011: begin
        p = longint'(int'(x)) * longint'(int'(y));
        r = p[31:0];
        h = p[63:32];
      end
      default: begin
        r = 32'd0;
        h = 32'd0;
      end
    endcase
  endtask

  // Drive one cycle of inputs after the falling edge.
  // Then check every output before the next rising edge, and record any store in the model.
  task automatic step(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] wd, input logic we, input logic re);
    logic [3:0]  c;
    logic [31:0] r;
    logic [31:0] h;
    logic [31:0] rd;
    int          idx;
    @(negedge clk);
    bus.alu_op = op;
    bus.funct = fn;
    bus.a = x;
    bus.b = y;
    bus.write_data = wd;
    bus.mem_write = we;
    bus.mem_read = re;
    #1;
    c = ref_ctrl(op, fn);
    ref_alu(c, x, y, r, h);
    idx = int'((r >> 2) & 32'(MW - 1));
    rd = (re && rst_n) ? model_mem[idx] : 32'd0;
    chk("ctrl", {60'd0, bus.alu_control}, {60'd0, c});
    chk("result", {32'd0, bus.alu_result}, {32'd0, r});
    chk("buffer", {32'd0, bus.buffer}, {32'd0, h});
    chk("zero", {63'd0, bus.zero}, {63'd0, (r == 32'd0)});
    chk("rdata", {32'd0, bus.read_data}, {32'd0, rd});
    if (we && rst_n) model_mem[idx] = wd;
  endtask

  task automatic clear_model();
    for (int i = 0; i < MW; i++) model_mem[i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b011000, 6'b000000};
    clear_model();
    rst_n = 1'b0;
    bus.alu_op = 2'b00;
    bus.funct = 6'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.write_data = 32'd0;
    bus.mem_write = 1'b0;
    bus.mem_read = 1'b0;

    // Reset state: read is gated and the ALU is purely combinational.
    step(2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("rst_rdata", {32'd0, bus.read_data}, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd1);
    #1 rst_n = 1'b1;

    // Decode sweep.
    step(2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("dec00", {60'd0, bus.alu_control}, 64'h2);
    step(2'b01, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("dec01", {60'd0, bus.alu_control}, 64'h6);
    step(2'b11, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("dec11", {60'd0, bus.alu_control}, 64'h1);
    for (int i = 0; i < 8; i++) step(2'b10, fn_tab[i], 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    step(2'b10, 6'b000000, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("dec_bad", {60'd0, bus.alu_control}, 64'hF);
    chk("bad_zero", {63'd0, bus.zero}, 64'd1);

    // ALU arithmetic corners.
    step(2'b00, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    chk("add_wrap", {32'd0, bus.alu_result}, 64'd0);
    chk("add_zero", {63'd0, bus.zero}, 64'd1);
    step(2'b01, 6'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("sub", {32'd0, bus.alu_result}, 64'hFFFFFFFE);
    step(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    chk("slt_neg", {32'd0, bus.alu_result}, 64'd1);
    step(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    chk("slt_pos", {32'd0, bus.alu_result}, 64'd0);
    step(2'b10, 6'b100111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("nor", {32'd0, bus.alu_result}, 64'hFFFFFFFF);
    step(2'b10, 6'b011000, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b0);
    chk("mul_lo", {32'd0, bus.alu_result}, 64'd0);
    chk("mul_hi", {32'd0, bus.buffer}, 64'd1);
    step(2'b10, 6'b011000, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b0, 1'b0);
    chk("muln_lo", {32'd0, bus.alu_result}, 64'hFFFFFFFA);
    chk("muln_hi", {32'd0, bus.buffer}, 64'hFFFFFFFF);

    // Store and load, byte-offset masking and aliasing.
    step(2'b00, 6'd0, 32'd8, 32'd4, 32'hDEADBEEF, 1'b1, 1'b0);
    step(2'b00, 6'd0, 32'd8, 32'd4, 32'd0, 1'b0, 1'b1);
    chk("ld12", {32'd0, bus.read_data}, 64'hDEADBEEF);
    step(2'b00, 6'd0, 32'd8, 32'd5, 32'd0, 1'b0, 1'b1);
    chk("ld13", {32'd0, bus.read_data}, 64'hDEADBEEF);
    step(2'b00, 6'd0, 32'd8, 32'd4 + 32'd4 * MW, 32'd0, 1'b0, 1'b1);
    chk("ld_alias", {32'd0, bus.read_data}, 64'hDEADBEEF);
    step(2'b00, 6'd0, 32'd8, 32'd4, 32'd0, 1'b0, 1'b0);
    chk("rd_gate", {32'd0, bus.read_data}, 64'd0);

    // Same-cycle read and write: the old value is visible before the edge and the new value after it.
    step(2'b00, 6'd0, 32'd8, 32'd4, 32'd1, 1'b1, 1'b0);
    step(2'b00, 6'd0, 32'd8, 32'd4, 32'd2, 1'b1, 1'b1);
    chk("rw_old", {32'd0, bus.read_data}, 64'd1);
    @(posedge clk);
    #1;
    chk("rw_new", {32'd0, bus.read_data}, 64'd2);

    // Randomized operations with memory traffic.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] fn;
      fn = ($urandom_range(1, 0) == 1) ? fn_tab[$urandom_range(7, 0)] : 6'($urandom);
      step(2'($urandom), fn, $urandom, $urandom, $urandom,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Reset: fill words 0..3, then pulse reset low between edges while a store is held.
    for (int i = 0; i < 4; i++) step(2'b00, 6'd0, 32'(i * 4), 32'd0, 32'hA0 + 32'(i), 1'b1, 1'b0);
    step(2'b00, 6'd0, 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("pre_rst", {32'd0, bus.read_data}, 64'hA1);
    bus.mem_write = 1'b1;
    bus.write_data = 32'h55;
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_now", {32'd0, bus.read_data}, 64'd0);
    for (int i = 0; i < 4; i++) step(2'b00, 6'd0, 32'(i * 4), 32'd0, 32'h55, 1'b1, 1'b1);
    step(2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst0", {32'd0, bus.read_data}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 6'd0, 32'(i * 4), 32'd0, 32'd0, 1'b0, 1'b1);
      chk("post_rst", {32'd0, bus.read_data}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
